// File: rtl/bel_slice.sv
// Slice of N_BELS LUT+FF cells sharing one serial configuration chain.
// Outputs are gated low until a complete configuration session has been shifted in.
module bel_slice #(
   parameter int unsigned INPUT_WIDTH = 6,
   parameter int unsigned N_BELS      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          prog_en,
   input  logic                          prog_in,
   output logic                          prog_out,
   output logic                          cfg_valid,
   input  logic [N_BELS*INPUT_WIDTH-1:0] bel_in,
   input  logic [N_BELS-1:0]             bel_ce,
   input  logic [N_BELS-1:0]             bel_sr,
   output logic [N_BELS-1:0]             bel_out
);

   localparam int unsigned K        = INPUT_WIDTH;
   localparam int unsigned LutBits  = 1 << K;
   localparam int unsigned W        = LutBits + 3;
   localparam int unsigned CFG_BITS = N_BELS * W;
   localparam int unsigned CntW     = $clog2(CFG_BITS + 1);

   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic [CntW-1:0]     prog_cnt_q, prog_cnt_d;
   logic                in_session_q, in_session_d;
   logic                prog_en_prev_q, prog_en_prev_d;
   logic [N_BELS-1:0]   ff_q, ff_d;

   logic [N_BELS-1:0]   lut_out;
   logic [N_BELS-1:0]   out_sel;
   logic [N_BELS-1:0]   ff_init;
   logic [N_BELS-1:0]   ff_init_nxt;
   logic [N_BELS-1:0]   ce_en;

   for (genvar b = 0; b < N_BELS; b++) begin : g_cell
      logic [LutBits-1:0] table_b;
      assign table_b        = cfg_q[b*W +: LutBits];
      assign lut_out[b]     = table_b[bel_in[b*K +: K]];
      assign out_sel[b]     = cfg_q[b*W + LutBits];
      assign ff_init[b]     = cfg_q[b*W + LutBits + 1];
      assign ce_en[b]       = cfg_q[b*W + LutBits + 2];
      // While shifting, the FF tracks the init bit of the config being loaded.
      assign ff_init_nxt[b] = cfg_d[b*W + LutBits + 1];
   end

   always_comb begin
      cfg_d          = cfg_q;
      prog_cnt_d     = prog_cnt_q;
      in_session_d   = in_session_q;
      prog_en_prev_d = prog_en;
      if (prog_en) begin
         cfg_d = {cfg_q[CFG_BITS-2:0], prog_in};
         if (!prog_en_prev_q) begin
            prog_cnt_d   = CntW'(1);
            in_session_d = 1'b1;
         end else if (prog_cnt_q != CntW'(CFG_BITS)) begin
            prog_cnt_d = prog_cnt_q + CntW'(1);
         end
      end
   end

   always_comb begin
      ff_d = ff_q;
      for (int b = 0; b < N_BELS; b++) begin
         if (prog_en) begin
            ff_d[b] = ff_init_nxt[b];
         end else if (bel_sr[b]) begin
            ff_d[b] = ff_init[b];
         end else if (!ce_en[b] || bel_ce[b]) begin
            ff_d[b] = lut_out[b];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_q          <= '0;
         prog_cnt_q     <= '0;
         in_session_q   <= 1'b0;
         prog_en_prev_q <= 1'b0;
         ff_q           <= '0;
      end else begin
         cfg_q          <= cfg_d;
         prog_cnt_q     <= prog_cnt_d;
         in_session_q   <= in_session_d;
         prog_en_prev_q <= prog_en_prev_d;
         ff_q           <= ff_d;
      end
   end

   assign prog_out  = cfg_q[CFG_BITS-1];
   assign cfg_valid = (prog_cnt_q == CntW'(CFG_BITS)) && !prog_en && in_session_q;

   always_comb begin
      bel_out = '0;
      for (int b = 0; b < N_BELS; b++) begin
         bel_out[b] = cfg_valid & (out_sel[b] ? ff_q[b] : lut_out[b]);
      end
   end

endmodule

// File: tb/tb_bel_slice.sv
// Directed bench for bel_slice with K=2, N_BELS=2 (7 config bits per cell, 14 total).
module tb_bel_slice;

   localparam int unsigned K  = 2;
   localparam int unsigned NB = 2;

   logic          clk;
   logic          rst;
   logic          prog_en;
   logic          prog_in;
   logic          prog_out;
   logic          cfg_valid;
   logic [NB*K-1:0] bel_in;
   logic [NB-1:0] bel_ce;
   logic [NB-1:0] bel_sr;
   logic [NB-1:0] bel_out;

   int n_tests;
   int n_fail;

   // BEL1 = XOR, registered, init 1; BEL0 = AND, combinational.
   logic [13:0] v1;
   // Same as v1 but BEL1 has ce_en set.
   logic [13:0] v2;
   logic [27:0] pat;

   bel_slice #(
      .INPUT_WIDTH(K),
      .N_BELS     (NB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .prog_en  (prog_en),
      .prog_in  (prog_in),
      .prog_out (prog_out),
      .cfg_valid(cfg_valid),
      .bel_in   (bel_in),
      .bel_ce   (bel_ce),
      .bel_sr   (bel_sr),
      .bel_out  (bel_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         prog_en = 1'b1;
         prog_in = v[i];
         tick();
      end
      prog_en = 1'b0;
      prog_in = 1'b0;
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      v1      = 14'b0110110_0001000;
      v2      = 14'b1110110_0001000;
      pat     = 28'hA5C396E;
      rst     = 1'b0;
      prog_en = 1'b0;
      prog_in = 1'b0;
      bel_in  = '0;
      bel_ce  = '0;
      bel_sr  = '0;
      #1;
      check_eq("reset_cfg_valid", 32'(cfg_valid), 32'd0);
      check_eq("reset_bel_out", 32'(bel_out), 32'd0);
      check_eq("reset_prog_out", 32'(prog_out), 32'd0);
      #11 rst = 1'b1;
      tick();

      // 1: basic program, comb AND and registered XOR
      shift_bits(32'(v1), 14);
      check_eq("t1_cfg_valid", 32'(cfg_valid), 32'd1);
      check_eq("t1_bel1_init", 32'(bel_out[1]), 32'd1);
      bel_in = 4'b1111;
      #1;
      check_eq("t1_and_11_comb", 32'(bel_out), 32'b11);
      tick();
      check_eq("t1_xor_11_reg", 32'(bel_out), 32'b01);
      bel_in = 4'b0101;
      #1;
      check_eq("t1_and_01_comb", 32'(bel_out), 32'b00);
      tick();
      check_eq("t1_xor_01_reg", 32'(bel_out), 32'b10);

      // 2: clock enable gating on BEL1
      shift_bits(32'(v2), 14);
      check_eq("t2_init", 32'(bel_out[1]), 32'd1);
      bel_in = 4'b1100;
      bel_ce = 2'b00;
      tick();
      check_eq("t2_ce_hold", 32'(bel_out[1]), 32'd1);
      bel_ce = 2'b10;
      tick();
      check_eq("t2_ce_update", 32'(bel_out[1]), 32'd0);
      bel_ce = 2'b00;

      // 5: sync set/reset beats disabled clock enable
      bel_sr = 2'b10;
      tick();
      check_eq("t5_sr_load", 32'(bel_out[1]), 32'd1);
      bel_sr = 2'b00;
      tick();
      check_eq("t5_hold_after_sr", 32'(bel_out[1]), 32'd1);

      // 3: short session never validates
      shift_bits(32'h2AA, 10);
      check_eq("t3_short_valid", 32'(cfg_valid), 32'd0);
      bel_in = 4'b1111;
      #1;
      check_eq("t3_out_11", 32'(bel_out), 32'd0);
      bel_in = 4'b0101;
      #1;
      check_eq("t3_out_01", 32'(bel_out), 32'd0);
      shift_bits(32'(v1), 14);
      check_eq("t3_full_valid", 32'(cfg_valid), 32'd1);
      check_eq("t3_full_out", 32'(bel_out), 32'b10);

      // 4: 28-bit pass-through; prog_out lags prog_in by 14 shifts
      for (int k = 1; k <= 28; k++) begin
         prog_en = 1'b1;
         prog_in = pat[28-k];
         tick();
         if (k >= 14) check_eq($sformatf("t4_prog_out_%0d", k), 32'(prog_out), 32'(pat[41-k]));
         if (k == 20) check_eq("t4_valid_during_shift", 32'(cfg_valid), 32'd0);
      end
      prog_en = 1'b0;
      #1;
      check_eq("t4_sat_valid", 32'(cfg_valid), 32'd1);

      // 6: async reset during run
      shift_bits(32'(v2), 14);
      bel_in = 4'b0011;
      #1;
      check_eq("t6_pre_out", 32'(bel_out), 32'b11);
      check_eq("t6_pre_prog_out", 32'(prog_out), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("t6_rst_out", 32'(bel_out), 32'd0);
      check_eq("t6_rst_valid", 32'(cfg_valid), 32'd0);
      check_eq("t6_rst_prog_out", 32'(prog_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_eq("t6_post_valid", 32'(cfg_valid), 32'd0);
      check_eq("t6_post_out", 32'(bel_out), 32'd0);

      // 6b: async reset mid-session
      for (int i = 0; i < 7; i++) begin
         prog_en = 1'b1;
         prog_in = 1'b1;
         tick();
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("t6b_rst_valid", 32'(cfg_valid), 32'd0);
      check_eq("t6b_rst_prog_out", 32'(prog_out), 32'd0);
      prog_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      shift_bits(32'h55, 7);
      check_eq("t6b_partial_valid", 32'(cfg_valid), 32'd0);
      shift_bits(32'(v1), 14);
      check_eq("t6b_full_valid", 32'(cfg_valid), 32'd1);
      check_eq("t6b_full_out", 32'(bel_out), 32'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
